// File: rtl/ipsl_pcie_dma_pkg.sv
// Shared definitions for the PCIe DMA receive path.
// This file holds the write-control FSM encoding and the maximum DW length.
package ipsl_pcie_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_t;

    localparam int unsigned MAX_LEN_DW = 1024;

    // A length field of zero encodes the maximum transfer.
    function automatic logic [10:0] decode_len(input logic [9:0] len_field);
        logic [10:0] len_v;
        if (len_field == 10'd0) begin
            len_v = 11'(MAX_LEN_DW);
        end else begin
            len_v = {1'b0, len_field};
        end
        return len_v;
    endfunction

endpackage

// File: rtl/ipsl_pcie_dma_dw_align.sv
// Re-aligns lane-0-packed payload beats to the RAM DW offset.
// A carry register holds the DWs that spill over into the next RAM word.
module ipsl_pcie_dma_dw_align
    import ipsl_pcie_dma_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         accept,
    input  logic [1:0]   off,
    input  logic         first,
    input  logic [2:0]   consume,
    input  logic [1:0]   flush_cnt,
    input  logic [127:0] beat,
    output logic [127:0] beat_data,
    output logic [15:0]  beat_be,
    output logic [127:0] flush_data,
    output logic [15:0]  flush_be
);

    logic [127:0] carry_r;
    logic [127:0] carry_next_s;

    // Lane mux, next carry contents and byte enables for beat and flush writes
    always_comb begin
        beat_data    = 128'd0;
        carry_next_s = 128'd0;
        beat_be      = 16'd0;
        flush_be     = 16'd0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(off)) begin
                beat_data[32*i +: 32]    = carry_r[32*i +: 32];
                carry_next_s[32*i +: 32] = beat[32*(4 - int'(off) + i) +: 32];
                beat_be[4*i +: 4]        = first ? 4'h0 : 4'hF;
            end else begin
                beat_data[32*i +: 32] = beat[32*(i - int'(off)) +: 32];
                beat_be[4*i +: 4]     = (i < int'(off) + int'(consume)) ? 4'hF : 4'h0;
            end
            flush_be[4*i +: 4] = (i < int'(flush_cnt)) ? 4'hF : 4'h0;
        end
    end

    // Carry register, cleared at the start of every transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_r <= 128'd0;
        end else if (clear) begin
            carry_r <= 128'd0;
        end else if (accept) begin
            carry_r <= carry_next_s;
        end else begin
            carry_r <= carry_r;
        end
    end

    assign flush_data = carry_r;

endmodule

// File: rtl/ipsl_pcie_dma_rx_cpld_wr_ctrl.sv
// Writes completion payload beats into a 128-bit BAR RAM at an arbitrary DW offset.
// Each accepted beat produces one registered RAM write; a final flush drains the carry.
module ipsl_pcie_dma_rx_cpld_wr_ctrl
    import ipsl_pcie_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_start,
    input  logic [9:0]            i_wr_length,
    input  logic [ADDR_WIDTH+1:0] i_wr_addr,
    input  logic [127:0]          i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_rx_last,
    output logic                  o_rx_ready,
    output logic                  o_bar_wr_en,
    output logic [ADDR_WIDTH-1:0] o_bar_wr_addr,
    output logic [127:0]          o_bar_wr_data,
    output logic [15:0]           o_bar_wr_be,
    output logic                  o_wr_busy,
    output logic                  o_wr_done,
    output logic                  o_len_err
);

    wr_state_t             state_r;
    wr_state_t             state_next_s;
    logic [10:0]           remain_r;
    logic [1:0]            off_r;
    logic                  first_r;
    logic [ADDR_WIDTH-1:0] waddr_r;
    logic [1:0]            flush_cnt_r;

    logic                  wr_en_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [127:0]          wr_data_r;
    logic [15:0]           wr_be_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  len_err_r;

    logic                  start_s;
    logic                  accept_s;
    logic                  last_beat_s;
    logic                  len_err_s;
    logic                  need_flush_s;
    logic [2:0]            consume_s;
    logic [2:0]            span_s;
    logic [127:0]          beat_data_s;
    logic [127:0]          flush_data_s;
    logic [15:0]           beat_be_s;
    logic [15:0]           flush_be_s;

    assign start_s      = (state_r == ST_IDLE) && i_wr_start;
    assign accept_s     = (state_r == ST_RECV) && i_rx_valid;
    assign last_beat_s  = (remain_r <= 11'd4);
    assign consume_s    = last_beat_s ? remain_r[2:0] : 3'd4;
    assign span_s       = {1'b0, off_r} + consume_s;
    assign need_flush_s = (span_s > 3'd4);
    assign len_err_s    = accept_s && (last_beat_s ? !i_rx_last : i_rx_last);

    ipsl_pcie_dma_dw_align u_align (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_s),
        .accept     (accept_s),
        .off        (off_r),
        .first      (first_r),
        .consume    (consume_s),
        .flush_cnt  (flush_cnt_r),
        .beat       (i_rx_data),
        .beat_data  (beat_data_s),
        .beat_be    (beat_be_s),
        .flush_data (flush_data_s),
        .flush_be   (flush_be_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode; a length error aborts without flushing
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_wr_start) begin
                    state_next_s = ST_RECV;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (len_err_s) begin
                    state_next_s = ST_IDLE;
                end else if (accept_s && last_beat_s) begin
                    state_next_s = need_flush_s ? ST_FLUSH : ST_DONE;
                end else begin
                    state_next_s = ST_RECV;
                end
            end
            ST_FLUSH: state_next_s = ST_DONE;
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Transfer bookkeeping: remaining DWs, offset, word address and flush size
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_r    <= 11'd0;
            off_r       <= 2'd0;
            first_r     <= 1'b0;
            waddr_r     <= '0;
            flush_cnt_r <= 2'd0;
        end else if (start_s) begin
            remain_r    <= decode_len(i_wr_length);
            off_r       <= i_wr_addr[1:0];
            first_r     <= 1'b1;
            waddr_r     <= i_wr_addr[ADDR_WIDTH+1:2];
            flush_cnt_r <= 2'd0;
        end else if (accept_s) begin
            remain_r    <= remain_r - {8'd0, consume_s};
            first_r     <= 1'b0;
            waddr_r     <= waddr_r + ADDR_WIDTH'(1);
            // Only meaningful when span exceeds 4: low bits give span - 4
            flush_cnt_r <= span_s[1:0];
        end else if (state_r == ST_FLUSH) begin
            waddr_r     <= waddr_r + ADDR_WIDTH'(1);
        end else begin
            remain_r    <= remain_r;
        end
    end

    // Registered RAM write port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 128'd0;
            wr_be_r   <= 16'd0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            len_err_r <= 1'b0;
        end else begin
            ready_r   <= (state_next_s == ST_RECV);
            busy_r    <= (state_next_s != ST_IDLE);
            done_r    <= (state_r == ST_DONE);
            len_err_r <= len_err_s;
            if (accept_s) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= waddr_r;
                wr_data_r <= beat_data_s;
                wr_be_r   <= beat_be_s;
            end else if (state_r == ST_FLUSH) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= waddr_r;
                wr_data_r <= flush_data_s;
                wr_be_r   <= flush_be_s;
            end else begin
                wr_en_r   <= 1'b0;
            end
        end
    end

    assign o_rx_ready    = ready_r;
    assign o_bar_wr_en   = wr_en_r;
    assign o_bar_wr_addr = wr_addr_r;
    assign o_bar_wr_data = wr_data_r;
    assign o_bar_wr_be   = wr_be_r;
    assign o_wr_busy     = busy_r;
    assign o_wr_done     = done_r;
    assign o_len_err     = len_err_r;

endmodule

// File: tb/tb_ipsl_pcie_dma_rx_cpld_wr_ctrl.sv
// Bench for the completion write controller: a DW-level memory model feeds a scoreboard queue.
// It also covers table-driven transfers, reset-state checks and a mid-transfer reset.
module tb_ipsl_pcie_dma_rx_cpld_wr_ctrl;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_wr_start = 1'b0;
    logic [9:0]    i_wr_length = 10'd0;
    logic [AW+1:0] i_wr_addr = '0;
    logic [127:0]  i_rx_data = 128'd0;
    logic          i_rx_valid = 1'b0;
    logic          i_rx_last = 1'b0;
    logic          o_rx_ready;
    logic          o_bar_wr_en;
    logic [AW-1:0] o_bar_wr_addr;
    logic [127:0]  o_bar_wr_data;
    logic [15:0]   o_bar_wr_be;
    logic          o_wr_busy;
    logic          o_wr_done;
    logic          o_len_err;

    always #5 clk = ~clk;

    ipsl_pcie_dma_rx_cpld_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_start    (i_wr_start),
        .i_wr_length   (i_wr_length),
        .i_wr_addr     (i_wr_addr),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .i_rx_last     (i_rx_last),
        .o_rx_ready    (o_rx_ready),
        .o_bar_wr_en   (o_bar_wr_en),
        .o_bar_wr_addr (o_bar_wr_addr),
        .o_bar_wr_data (o_bar_wr_data),
        .o_bar_wr_be   (o_bar_wr_be),
        .o_wr_busy     (o_wr_busy),
        .o_wr_done     (o_wr_done),
        .o_len_err     (o_len_err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [127:0]  data;
        logic [15:0]   be;
    } wr_t;

    // lastmode: 0 = last on final beat, 1 = last on beat 0 (early), 2 = last never set
    typedef struct {
        int addr;
        int len;
        bit gaps;
        int lastmode;
        bit spur;
        int exp_writes;
        int exp_done;
        int exp_err;
    } vec_t;

    wr_t   exp_q[$];
    vec_t  vecs[12];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    wr_seen = 0;
    int    done_seen = 0;
    int    err_seen = 0;
    int    last_wr_cyc = 0;
    int    done_cyc = 0;
    wr_t   mon_e;
    logic [127:0] mon_m;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_i(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] dwval(input int tc, input int k);
        return {8'hA5, 8'(tc), 16'(k)};
    endfunction

    function automatic logic [127:0] bytemask(input logic [15:0] be);
        logic [127:0] m;
        m = 128'd0;
        for (int j = 0; j < 16; j++) m[8*j +: 8] = {8{be[j]}};
        return m;
    endfunction

    // Reference model: place each payload DW at its own DW address, group by RAM word
    task automatic push_model(input int tc, input int addr, input int ndw);
        int off = addr % 4;
        int nw = (off + ndw + 3) / 4;
        for (int j = 0; j < nw; j++) begin
            wr_t w;
            w.addr = AW'(((addr / 4) + j) % 512);
            w.data = 128'd0;
            w.be   = 16'd0;
            for (int l = 0; l < 4; l++) begin
                int k = j * 4 + l - off;
                if (k >= 0 && k < ndw) begin
                    w.data[32*l +: 32] = dwval(tc, k);
                    w.be[4*l +: 4]     = 4'hF;
                end
            end
            exp_q.push_back(w);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard monitor: pops one expected write per observed RAM strobe
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_bar_wr_en === 1'b1) begin
                    wr_seen++;
                    last_wr_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 128'(o_bar_wr_addr), 128'h1_0000);
                    end else begin
                        mon_e = exp_q.pop_front();
                        mon_m = bytemask(mon_e.be);
                        check("wr_addr", 128'(o_bar_wr_addr), 128'(mon_e.addr));
                        check("wr_be", 128'(o_bar_wr_be), 128'(mon_e.be));
                        check("wr_data", o_bar_wr_data & mon_m, mon_e.data & mon_m);
                    end
                end
                if (o_wr_done === 1'b1) begin
                    done_seen++;
                    done_cyc = cyc;
                end
                if (o_len_err === 1'b1) err_seen++;
            end
        end
    end

    task automatic run_vec(input int tc, input vec_t v);
        int nbeats;
        int ndw;
        bit ok;
        wr_seen = 0; done_seen = 0; err_seen = 0; done_cyc = 0; last_wr_cyc = 0;
        ndw    = (v.lastmode == 1) ? 4 : v.len;
        nbeats = (v.lastmode == 1) ? 1 : (v.len + 3) / 4;
        push_model(tc, v.addr, ndw);
        @(negedge clk);
        i_wr_start  = 1'b1;
        i_wr_length = 10'(v.len);
        i_wr_addr   = (AW+2)'(v.addr);
        @(negedge clk);
        i_wr_start = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < 4; l++) begin
                int k = 4 * b + l;
                i_rx_data[32*l +: 32] = (k < v.len) ? dwval(tc, k) : (32'hBAD0_0000 | 32'(k));
            end
            i_rx_valid = 1'b1;
            i_rx_last  = (v.lastmode != 2) && (b == nbeats - 1);
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                if (o_rx_ready === 1'b1) ok = 1'b1;
                @(negedge clk);
            end
            i_rx_valid = 1'b0;
            i_rx_last  = 1'b0;
            if (!ok) begin
                check_i("rx_ready_timeout", 0, 1);
                break;
            end
            if (v.lastmode != 0 && b == nbeats - 1) check("busy_after_err", 128'(o_wr_busy), 128'd0);
            if (v.spur && b == 0) begin
                i_wr_start  = 1'b1;
                i_wr_addr   = '0;
                i_wr_length = 10'd1;
                @(negedge clk);
                i_wr_start = 1'b0;
            end
            if (v.gaps) @(negedge clk);
        end
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (o_wr_busy === 1'b0) ok = 1'b1;
            else @(negedge clk);
        end
        check_i("busy_drop", int'(ok), 1);
        repeat (2) @(negedge clk);
        check_i("write_count", wr_seen, v.exp_writes);
        check_i("done_count", done_seen, v.exp_done);
        check_i("len_err_count", err_seen, v.exp_err);
        check_i("queue_left", exp_q.size(), 0);
        if (v.exp_done != 0) check_i("done_latency", done_cyc - last_wr_cyc, 1);
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 128'(o_rx_ready), 128'd0);
        check({tag, "_wr_en"}, 128'(o_bar_wr_en), 128'd0);
        check({tag, "_wr_addr"}, 128'(o_bar_wr_addr), 128'd0);
        check({tag, "_wr_data"}, o_bar_wr_data, 128'd0);
        check({tag, "_wr_be"}, 128'(o_bar_wr_be), 128'd0);
        check({tag, "_busy"}, 128'(o_wr_busy), 128'd0);
        check({tag, "_done"}, 128'(o_wr_done), 128'd0);
        check({tag, "_len_err"}, 128'(o_len_err), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        vecs[0]  = '{40,   8,    1'b0, 0, 1'b0, 2,   1, 0};
        vecs[1]  = '{81,   4,    1'b0, 0, 1'b0, 2,   1, 0};
        vecs[2]  = '{123,  1,    1'b0, 0, 1'b0, 1,   1, 0};
        vecs[3]  = '{23,   6,    1'b0, 0, 1'b0, 3,   1, 0};
        vecs[4]  = '{30,   7,    1'b1, 0, 1'b0, 3,   1, 0};
        vecs[5]  = '{2046, 2,    1'b0, 0, 1'b0, 1,   1, 0};
        vecs[6]  = '{2041, 11,   1'b1, 0, 1'b0, 3,   1, 0};
        vecs[7]  = '{1200, 1024, 1'b1, 0, 1'b0, 256, 1, 0};
        vecs[8]  = '{0,    8,    1'b0, 1, 1'b0, 1,   0, 1};
        vecs[9]  = '{16,   4,    1'b0, 2, 1'b0, 1,   0, 1};
        vecs[10] = '{800,  8,    1'b0, 0, 1'b1, 2,   1, 0};
        vecs[11] = '{403,  1024, 1'b0, 0, 1'b0, 257, 1, 0};

        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("post_reset_idle");

        for (int i = 0; i < 12; i++) run_vec(i + 1, vecs[i]);

        // Mid-transfer reset: beat 0 of a 12-DW transfer, then reset while in RECV
        wr_seen = 0;
        push_model(40, 64, 4);
        @(negedge clk);
        i_wr_start  = 1'b1;
        i_wr_length = 10'd12;
        i_wr_addr   = (AW+2)'(64);
        @(negedge clk);
        i_wr_start = 1'b0;
        for (int l = 0; l < 4; l++) i_rx_data[32*l +: 32] = dwval(40, l);
        i_rx_valid = 1'b1;
        check("mid_ready_before", 128'(o_rx_ready), 128'd1);
        @(negedge clk);
        i_rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_i("mid_reset_writes", wr_seen, 1);
        check_i("mid_reset_queue", exp_q.size(), 0);
        check("mid_reset_busy", 128'(o_wr_busy), 128'd0);
        exp_q.delete();

        rv = '{64, 4, 1'b0, 0, 1'b0, 1, 1, 0};
        run_vec(41, rv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
